spi_input_conditioner: RTL and testbench

- Front-end stage directly upstream of the SPI control FSM and shift register.
- Takes raw asynchronous SPI pins (sclk, cs, mosi) and synchronizes each one into the clk domain.
- Debounces each pin and produces a clean level plus one-cycle rising/falling edge pulses.
- Downstream logic steps on the sclk edge pulses and cs level, never on the raw pins.

---
 rtl/spi_input_conditioner_if.sv | 22 ++
 rtl/spi_input_conditioner.sv | 67 ++++++
 tb/tb_spi_input_conditioner.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/spi_input_conditioner_if.sv
// Pin bundle between the raw SPI pads and the conditioner.
// The slave side (conditioner) samples noisy and drives the clean outputs.
interface spi_input_conditioner_if;
    logic [2:0] noisy;
    logic [2:0] conditioned;
    logic [2:0] rising;
    logic [2:0] falling;

    modport master (
        output noisy,
        input  conditioned,
        input  rising,
        input  falling
    );

    modport slave (
        input  noisy,
        output conditioned,
        output rising,
        output falling
    );
endinterface

// File: rtl/spi_input_conditioner.sv
// Synchronizes and debounces sclk/cs/mosi; emits clean levels and
// one-cycle edge pulses for the downstream SPI FSM.
module spi_input_conditioner #(
    parameter int unsigned WAIT_TIME  = 3,
    parameter int unsigned CNT_WIDTH  = 3,
    parameter logic [2:0]  IDLE_VALUE = 3'b010
) (
    input logic                    clk,
    input logic                    reset,
    spi_input_conditioner_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] WAIT_C = CNT_WIDTH'(WAIT_TIME);
    localparam logic [CNT_WIDTH-1:0] ONE_C  = CNT_WIDTH'(1);

    logic [2:0]           sync0_q, sync1_q;
    logic [2:0]           cond_q, cond_d;
    logic [2:0]           rise_q, rise_d;
    logic [2:0]           fall_q, fall_d;
    logic [CNT_WIDTH-1:0] cnt_q [3];
    logic [CNT_WIDTH-1:0] cnt_d [3];

    // Per-channel debounce; a mismatch must persist WAIT_TIME+1 edges.
    always_comb begin
        cond_d = cond_q;
        rise_d = '0;
        fall_d = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync1_q[i] == cond_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == WAIT_C) begin
                cond_d[i] = sync1_q[i];
                cnt_d[i]  = '0;
                rise_d[i] = sync1_q[i];
                fall_d[i] = ~sync1_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + ONE_C;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q <= IDLE_VALUE;
            sync1_q <= IDLE_VALUE;
            cond_q  <= IDLE_VALUE;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync0_q <= bus.noisy;
            sync1_q <= sync0_q;
            cond_q  <= cond_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.conditioned = cond_q;
    assign bus.rising      = rise_q;
    assign bus.falling     = fall_q;
endmodule

// File: tb/tb_spi_input_conditioner.sv
// Randomized bench for spi_input_conditioner against a run-length
// reference model plus directed latency/glitch/sweep scenarios.
module tb_spi_input_conditioner;
    localparam int         W    = 3;
    localparam logic [2:0] IDLE = 3'b010;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    spi_input_conditioner_if bus ();

    spi_input_conditioner #(
        .WAIT_TIME (W),
        .CNT_WIDTH (3),
        .IDLE_VALUE(IDLE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pins reach the debouncer two edges late; a level is
    // accepted once it has differed for W+1 consecutive edges.
    logic [2:0] m_hist [2];
    logic [2:0] m_cond;
    logic [2:0] m_rise;
    logic [2:0] m_fall;
    int         m_run [3];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [2:0] n, input logic r);
        logic [2:0] d;
        if (r) begin
            m_hist[0] = IDLE;
            m_hist[1] = IDLE;
            m_cond    = IDLE;
            m_rise    = '0;
            m_fall    = '0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
        end else begin
            d         = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = n;
            m_rise    = '0;
            m_fall    = '0;
            for (int i = 0; i < 3; i++) begin
                if (d[i] != m_cond[i]) begin
                    m_run[i]++;
                    if (m_run[i] == W + 1) begin
                        m_cond[i] = d[i];
                        m_rise[i] = d[i];
                        m_fall[i] = ~d[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    // One clock: drive, let the edge happen, compare on the falling edge.
    task automatic step(input logic [2:0] n, input logic r);
        bus.noisy = n;
        reset     = r;
        @(posedge clk);
        model_edge(n, r);
        @(negedge clk);
        check("cond", 32'(bus.conditioned), 32'(m_cond));
        check("rise", 32'(bus.rising), 32'(m_rise));
        check("fall", 32'(bus.falling), 32'(m_fall));
    endtask

    int         first_a, first_b, cnt_a, cnt_b;
    logic [2:0] pins;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        bus.noisy = IDLE;
        reset     = 1'b1;
        @(negedge clk);

        // Idle hold: nothing may move.
        step(IDLE, 1'b1);
        for (int k = 0; k < 20; k++) step(IDLE, 1'b0);
        check("idle_cond", 32'(bus.conditioned), 32'(IDLE));

        // Clean sclk rise: pulse after edge N+5, gone after N+6.
        first_a = -1;
        for (int k = 0; k < 10; k++) begin
            step(3'b011, 1'b0);
            if (bus.rising[0] && first_a < 0) first_a = k;
            if (k == 6) check("rise_gone", 32'(bus.rising[0]), 32'd0);
        end
        check("sclk_lat", 32'(first_a), 32'd5);

        // cs glitch low for two cycles must be swallowed.
        step(3'b010, 1'b0);
        for (int k = 0; k < 8; k++) step(3'b010, 1'b0);
        cnt_a = 0;
        for (int k = 0; k < 14; k++) begin
            step((k == 0 || k == 1) ? 3'b000 : 3'b010, 1'b0);
            if (bus.falling[1]) cnt_a++;
        end
        check("glitch_cnt", 32'(cnt_a), 32'd0);
        check("glitch_cs", 32'(bus.conditioned[1]), 32'd1);

        // cs falls, mosi rises one cycle later.
        first_a = -1;
        first_b = -1;
        cnt_a   = 0;
        cnt_b   = 0;
        for (int k = 0; k < 12; k++) begin
            step((k == 0) ? 3'b000 : 3'b100, 1'b0);
            if (bus.falling[1]) begin
                cnt_a++;
                if (first_a < 0) first_a = k;
            end
            if (bus.rising[2]) begin
                cnt_b++;
                if (first_b < 0) first_b = k;
            end
        end
        check("cs_lat", 32'(first_a), 32'd5);
        check("mosi_lat", 32'(first_b), 32'd6);
        check("cs_width", 32'(cnt_a), 32'd1);
        check("mosi_width", 32'(cnt_b), 32'd1);

        // Reset mid-debounce, then full latency from first new sample.
        step(IDLE, 1'b1);
        for (int k = 0; k < 4; k++) step(3'b011, 1'b0);
        step(3'b011, 1'b1);
        check("rst_cond", 32'(bus.conditioned), 32'(IDLE));
        check("rst_rise", 32'(bus.rising), 32'd0);
        first_a = -1;
        for (int k = 0; k < 10; k++) begin
            step(3'b011, 1'b0);
            if (bus.rising[0] && first_a < 0) first_a = k;
        end
        check("rst_lat", 32'(first_a), 32'd5);

        // sclk sweep at 1/16 rate.
        step(IDLE, 1'b1);
        for (int k = 0; k < 8; k++) step(IDLE, 1'b0);
        cnt_a = 0;
        cnt_b = 0;
        for (int p = 0; p < 16; p++) begin
            for (int k = 0; k < 16; k++) begin
                step((k < 8) ? 3'b011 : 3'b010, 1'b0);
                cnt_a += int'(bus.rising[0]);
                cnt_b += int'(bus.falling[0]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            step(IDLE, 1'b0);
            cnt_a += int'(bus.rising[0]);
            cnt_b += int'(bus.falling[0]);
        end
        check("sweep_rise", 32'(cnt_a), 32'd16);
        check("sweep_fall", 32'(cnt_b), 32'd16);

        // Random pins with short and long holds, rare resets.
        pins = IDLE;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 5) == 0) pins[i] = ~pins[i];
            end
            step(pins, ($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
